control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath's control inputs one control step per Clock cycle, replacing hand-sequenced bench stimulus.
- Performs the instruction fetch (T0–T2), decodes IR[31:27], then runs the per-class execute steps (T3–T7).
- Consumes IR and CON_out from the Datapath and Mem_ready from memory; produces register-select, bus-drive, latch-enable and memory strobes.

Parameters:
- USE_MEM_READY, 1: 1 = hold memory steps until Mem_ready=1; 0 = every memory step lasts exactly one cycle and Mem_ready is ignored.
- HALT_OP, 5'b11011: opcode that enters HALT.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Clear  input  1  asynchronous, active-low reset.
- IR  input  32  instruction register contents; opcode = IR[31:27].
- CON_out  input  1  branch condition flag from the Datapath CON logic.
- Mem_ready  input  1  memory has completed the current read or write.
- Stop  input  1  halt request, sampled only at instruction end.
- PCout, Zlowout, MDRout, Cout, BAout, Rout  output  1 each  bus-drive selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin  output  1 each  register load enables.
- Gra, Grb, Grc  output  1 each  register-field selects (Ra/Rb/Rc).
- IncPC, Read, Write  output  1 each  PC-increment and memory strobes.
- ALU_op  output  5  ALU operation code; 5'b00011 (ADD) except where stated.
- Step  output  4  current control step, T0=0..T7=7; 4'hF in RESET/HALT.
- Run  output  1  1 while executing; 0 in RESET and HALT.

Behaviour:
- State register: RESET, T0..T7, HALT. Outputs are decoded combinationally from state; the only exceptions are PCin in br T6 (also gated by CON_out) and the execute-step ALU_op (taken from IR[31:27]).
- Clear=0, asynchronous: state = RESET, all control outputs 0, ALU_op=0, Run=0, Step=4'hF. First rising edge after Clear=1 moves to T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - Then T3, decoded from IR[31:27].
- Execute sequences by opcode:
  - add 00011, sub 00100, and 00101, or 00110: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,ALU_op=opcode; T5 Zlowout,Gra,Rin.
  - addi 01100: T3 Grb,Rout,Yin; T4 Cout,Zin,ALU_op=ADD; T5 Zlowout,Gra,Rin.
  - ldi 00001: as addi but T3 uses BAout instead of Rout.
  - ld 00000: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
  - br 10010: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin; T6 Zlowout, with PCin = CON_out.
  - jr 10011: T3 Gra,Rout,PCin.
  - nop 11010 and any undefined opcode: T3 with all outputs 0.
  - HALT_OP: T3 goes to HALT.
- Memory wait: in T1 (fetch), ld T6 and st T7 with USE_MEM_READY=1, the state holds while Mem_ready=0 and the strobes stay asserted. The step advances on the first edge where Mem_ready=1.
- Instruction end is the last listed step of each sequence:
  - If Stop=1, go to HALT; otherwise go to T0.
  - Stop asserted mid-instruction has no effect until instruction end.
  - Stop sampled at an instruction's end halts before the next fetch.
- HALT: all control outputs 0, Run=0. It is exited only by Clear.
- No load-enable and bus-drive pair is ever asserted for the same register in the same step. At most one bus driver is active per step.
- Clear asserted mid-instruction (including during a memory wait) drops all strobes immediately. No partial write completes after Clear.

Test Plan:
- Reset: Clear=0 for 3 cycles, then 1 -> outputs all 0 and Step=F during reset; the first edge after release gives Step=0 with PCout=MARin=IncPC=Zin=1.
- add R1,R2,R3 (IR=32'h18918000), Mem_ready=1 -> Steps 0,1,2,3,4,5,0; ALU_op=00011 in T4; Gra=Rin=Zlowout=1 in T5; 6 cycles total.
- ld with Mem_ready low for 2 cycles in T6 -> Step stays 6 for 3 cycles with Read=MDRin=1, then T7 asserts MDRout,Gra,Rin.
- br with CON_out=1 vs CON_out=0 -> in T6 PCin=1 vs PCin=0; Zlowout=1 in both cases; next Step=0.
- Opcode 11011 -> HALT after T3; Run=0 and Step=F; stays halted for 10 cycles despite Stop=0; only Clear recovers.
- Clear pulsed low during st T7 wait -> Write deasserts asynchronously; Step returns to 0 after release; Stop=1 at an add's T5 gives HALT with no T0.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for the Datapath. Steps through the instruction
//   fetch (T0-T2), decodes IR[31:27] and runs the execute steps (T3-T7) of
//   each instruction class, one control step per Clock cycle.
//
// Ports
//   Clock      in   system clock, rising edge
//   Clear      in   asynchronous active-low reset
//   IR[31:0]   in   instruction register, opcode = IR[31:27]
//   CON_out    in   branch condition from the Datapath CON logic
//   Mem_ready  in   memory has completed the current read/write
//   Stop       in   halt request, honoured only at instruction end
//   PCout, Zlowout, MDRout, Cout, BAout, Rout            out  bus-drive selects
//   MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin       out  load enables
//   Gra, Grb, Grc                                        out  register-field selects
//   IncPC, Read, Write                                   out  PC increment / memory strobes
//   ALU_op[4:0]  out  ALU operation (ADD unless an ALU-class T4)
//   Step[3:0]    out  current step 0..7, 4'hF in RESET/HALT
//   Run          out  high while executing
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int unsigned USE_MEM_READY = 1,
  parameter logic [4:0]  HALT_OP       = 5'b11011
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_out,
  input  logic        Mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_op,
  output logic [3:0]  Step,
  output logic        Run
);

  // T-states are encoded with their step number so Step is a direct copy.
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_RESET = 4'd8,
    S_HALT  = 4'd9
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;

  state_e     state_q, state_d;
  state_e     end_state;
  logic [4:0] opcode;
  logic       is_alu, is_imm, is_ldst, is_ld, is_st, is_br, is_jr;
  logic       mem_done;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_LDI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_ldst = is_ld || is_st;
  assign is_br   = (opcode == OP_BR);
  assign is_jr   = (opcode == OP_JR);

  // With the handshake disabled every memory step completes in one cycle.
  assign mem_done  = (USE_MEM_READY == 0) || Mem_ready;
  // Where the last step of an instruction goes; Stop only matters here.
  assign end_state = Stop ? S_HALT : S_T0;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Rin = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    ALU_op = OP_ADD;
    Step   = state_q;
    Run    = 1'b1;

    case (state_q)
      S_RESET: begin
        ALU_op  = 5'b00000;
        Step    = 4'hF;
        Run     = 1'b0;
        state_d = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_done) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        // HALT_OP is tested first so an overridden value always wins.
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (is_alu || opcode == OP_ADDI) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (opcode == OP_LDI || is_ldst) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          state_d = S_T4;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          state_d = end_state;
        end else begin
          state_d = end_state;
        end
      end
      S_T4: begin
        state_d = S_T5;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = opcode;
        end else if (is_imm || is_ldst) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          state_d = S_T0;
        end
      end
      S_T5: begin
        if (is_alu || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_d = end_state;
        end else if (is_ldst) begin
          Zlowout = 1'b1; MARin = 1'b1;
          state_d = S_T6;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1;
          state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
          if (mem_done) state_d = S_T7;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          state_d = S_T7;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = CON_out;
          state_d = end_state;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_d = end_state;
        end else if (is_st) begin
          Write = 1'b1;
          if (mem_done) state_d = end_state;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT: begin
        ALU_op = 5'b00000;
        Step   = 4'hF;
        Run    = 1'b0;
      end
      default: begin
        ALU_op  = 5'b00000;
        Step    = 4'hF;
        Run     = 1'b0;
        state_d = S_RESET;
      end
    endcase
  end

endmodule
